// File: rtl/imu_sim_pkg.sv
// IMU model shared definitions: register map
// indices and the 16-bit SPI command layout.
package imu_sim_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [5:0] SAMPLE_CNT = 6'h01;
  localparam logic [5:0] GYRO_X     = 6'h02;
  localparam logic [5:0] GYRO_Y     = 6'h03;
  localparam logic [5:0] GYRO_Z     = 6'h04;
  localparam logic [5:0] ACCEL_X    = 6'h05;
  localparam logic [5:0] ACCEL_Y    = 6'h06;
  localparam logic [5:0] ACCEL_Z    = 6'h07;
  localparam logic [5:0] PROD_ID_W  = 6'h39;

  // wr, word index, high-byte select, byte data
  typedef struct packed {
    logic       wr;
    logic [5:0] word;
    logic       hi;
    logic [7:0] data;
  } spi_cmd_t;

  function automatic logic spi_writable(
    input logic [5:0] w
  );
    return (w > ACCEL_Z) && (w != PROD_ID_W);
  endfunction

endpackage

// File: rtl/imu_spi_slave16.sv
// Mode-3 16-bit SPI slave, oversampled on c
// through 2-flop synchronizers.
module imu_spi_slave16
  import imu_sim_pkg::*;
(
  input  logic        c,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  input  logic [15:0] resp,
  output logic        miso,
  output logic        frame_done,
  output logic        bad_frame,
  output logic [15:0] frame
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  logic [2:0]    cs_q;
  logic [2:0]    sck_q;
  logic [1:0]    mosi_q;
  logic          act;
  logic [CW-1:0] nbits;
  logic [15:0]   sh_in;
  logic [15:0]   sh_out;
  logic          cs_fall;
  logic          cs_rise;
  logic          sck_rise;
  logic          sck_fall;
  logic          full;

  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign full     = (nbits == CW'(FRAME_BITS));
  assign miso     = act & sh_out[15];
  assign frame    = sh_in;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= '1;
      sck_q  <= '1;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], cs};
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // first fall precedes any sample, so it keeps the MSB
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      act        <= 1'b0;
      nbits      <= '0;
      sh_in      <= '0;
      sh_out     <= '0;
      frame_done <= 1'b0;
      bad_frame  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      bad_frame  <= 1'b0;
      if (cs_fall) begin
        act    <= 1'b1;
        nbits  <= '0;
        sh_out <= resp;
      end else if (cs_rise) begin
        act        <= 1'b0;
        frame_done <= act & full;
        bad_frame  <= act & ~full;
      end else if (act && sck_rise && !full) begin
        sh_in <= {sh_in[14:0], mosi_q[1]};
        nbits <= nbits + CW'(1);
      end else if (act && sck_fall && nbits != '0) begin
        sh_out <= {sh_out[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/imu_sim_model.sv
// Behavioural SPI IMU: sample timer, 64x16 register
// file, host RAM port and pipelined SPI responses.
module imu_sim_model
  import imu_sim_pkg::*;
#(
  parameter int          SAMPLE_CYCLES = 62500,
  parameter int          SPEEDUP       = 1,
  parameter int          SYNC_WIDTH    = 8,
  parameter logic [15:0] PROD_ID       = 16'h404C
) (
  input  logic        c,
  input  logic        rst_n,
  output logic        sync_out,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  input  logic [7:0]  addr,
  input  logic        wr,
  input  logic [31:0] d,
  output logic [31:0] q
);

  localparam int P  = SAMPLE_CYCLES / SPEEDUP;
  localparam int TW = (P > 1) ? $clog2(P) : 1;

  logic [TW-1:0] tmr;
  logic          wrap;
  logic [15:0]   scnt;
  logic [15:0]   scnt_nx;
  logic [15:0]   regs [64];
  logic [15:0]   resp;
  logic [15:0]   frame;
  logic          frame_done;
  logic          bad_frame;
  spi_cmd_t      cmd;
  logic          host_sel;
  logic          host_we;
  logic          spi_we;
  logic [15:0]   spi_old;
  logic [15:0]   spi_wdata;
  logic          unused_bits;

  assign wrap      = (tmr == TW'(P - 1));
  assign scnt_nx   = scnt + 16'd1;
  assign cmd       = spi_cmd_t'(frame);
  assign host_sel  = (addr[7:6] == 2'b00);
  assign host_we   = wr & host_sel
                   & (addr[5:0] != PROD_ID_W);
  assign spi_we    = frame_done & cmd.wr
                   & spi_writable(cmd.word);
  assign spi_old   = regs[cmd.word];
  assign spi_wdata = cmd.hi
                   ? {cmd.data, spi_old[7:0]}
                   : {spi_old[15:8], cmd.data};
  assign unused_bits = ^{d[31:16], bad_frame};

  imu_spi_slave16 u_spi (
    .c          (c),
    .rst_n      (rst_n),
    .cs         (cs),
    .sck        (sck),
    .mosi       (mosi),
    .resp       (resp),
    .miso       (miso),
    .frame_done (frame_done),
    .bad_frame  (bad_frame),
    .frame      (frame)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      scnt     <= '0;
      sync_out <= 1'b0;
    end else begin
      if (wrap) begin
        tmr      <= '0;
        scnt     <= scnt_nx;
        sync_out <= 1'b1;
      end else begin
        tmr <= tmr + TW'(1);
        if (tmr == TW'(SYNC_WIDTH - 1))
          sync_out <= 1'b0;
      end
    end
  end

  // later assignments win: sample > host > SPI
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++)
        regs[6'(i)] <= '0;
      regs[PROD_ID_W] <= PROD_ID;
    end else begin
      if (spi_we)
        regs[cmd.word] <= spi_wdata;
      if (host_we)
        regs[addr[5:0]] <= d[15:0];
      if (wrap) begin
        regs[SAMPLE_CNT] <= scnt_nx;
        regs[GYRO_X]  <= {GYRO_X[3:0], scnt_nx[11:0]};
        regs[GYRO_Y]  <= {GYRO_Y[3:0], scnt_nx[11:0]};
        regs[GYRO_Z]  <= {GYRO_Z[3:0], scnt_nx[11:0]};
        regs[ACCEL_X] <= {ACCEL_X[3:0], scnt_nx[11:0]};
        regs[ACCEL_Y] <= {ACCEL_Y[3:0], scnt_nx[11:0]};
        regs[ACCEL_Z] <= {ACCEL_Z[3:0], scnt_nx[11:0]};
      end
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      resp <= '0;
    end else begin
      q <= host_sel ? {16'h0, regs[addr[5:0]]} : '0;
      if (frame_done)
        resp <= cmd.wr ? 16'h0 : spi_old;
    end
  end

endmodule

// File: tb/tb_imu_sim_model.sv
// Self-checking bench for imu_sim_model: host table,
// sample timing and SPI frame sequences via scoreboard.
module tb_imu_sim_model;

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b1;
  logic        sck = 1'b1;
  logic        mosi = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] d = '0;
  logic        sync_out;
  logic        miso;
  logic [31:0] q;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rel = 0;
  logic [31:0] sbq[$];

  typedef struct {
    logic [7:0]  a;
    logic        w;
    logic [31:0] dd;
    logic [31:0] e;
  } hv_t;
  hv_t tab[13];

  imu_sim_model #(
    .SAMPLE_CYCLES (62500),
    .SPEEDUP       (400),
    .SYNC_WIDTH    (8),
    .PROD_ID       (16'h404C)
  ) dut (
    .c        (c),
    .rst_n    (rst_n),
    .sync_out (sync_out),
    .cs       (cs),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .addr     (addr),
    .wr       (wr),
    .d        (d),
    .q        (q)
  );

  always #4 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm,
                          input logic [31:0] act);
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %h",
               nm, act);
    end else begin
      chk(nm, act, sbq.pop_front());
    end
  endtask

  task automatic wait_c(input int n);
    repeat (n) @(posedge c);
    #1;
  endtask

  task automatic host_op(input logic [7:0] a,
                         input logic w,
                         input logic [31:0] dd,
                         input logic [31:0] e,
                         input string nm);
    addr = a;
    wr = w;
    d = dd;
    sbq.push_back(e);
    wait_c(1);
    wr = 1'b0;
    sb_check(nm, q);
  endtask

  task automatic wait_rise(output int at);
    at = -100000;
    for (int i = 0; i < 400; i++) begin
      wait_c(1);
      if (sync_out) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic sync_width(output int w);
    w = 1;
    for (int i = 0; i < 50; i++) begin
      wait_c(1);
      if (!sync_out) break;
      w++;
    end
  endtask

  task automatic spi_bit(input logic b,
                         output logic r);
    sck = 1'b0;
    mosi = b;
    wait_c(8);
    r = miso;
    sck = 1'b1;
    wait_c(8);
  endtask

  task automatic spi_frame(input logic [15:0] tx,
                           input int n,
                           input logic [15:0] exp,
                           input string nm);
    logic [15:0] rx;
    logic r;
    rx = '0;
    sbq.push_back({16'h0, exp});
    cs = 1'b0;
    wait_c(8);
    for (int i = 0; i < n; i++) begin
      spi_bit(tx[15-i], r);
      rx[15-i] = r;
    end
    wait_c(4);
    cs = 1'b1;
    wait_c(8);
    sb_check(nm, {16'h0, rx});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int r1, r2, r3, w;
    logic [15:0] tx;
    logic r;

    tab[0]  = '{8'h39, 1'b0, 32'h0,         32'h404C};
    tab[1]  = '{8'h39, 1'b1, 32'h0,         32'h404C};
    tab[2]  = '{8'h39, 1'b0, 32'h0,         32'h404C};
    tab[3]  = '{8'h40, 1'b0, 32'h0,         32'h0};
    tab[4]  = '{8'h0A, 1'b1, 32'hBEEF,      32'h0};
    tab[5]  = '{8'h0A, 1'b0, 32'h0,         32'hBEEF};
    tab[6]  = '{8'h4A, 1'b1, 32'h1111,      32'h0};
    tab[7]  = '{8'h0A, 1'b0, 32'h0,         32'hBEEF};
    tab[8]  = '{8'h00, 1'b1, 32'hA5A5,      32'h0};
    tab[9]  = '{8'h00, 1'b0, 32'h0,         32'hA5A5};
    tab[10] = '{8'h3F, 1'b1, 32'hDEADFFFF,  32'h0};
    tab[11] = '{8'h3F, 1'b0, 32'h0,         32'hFFFF};
    tab[12] = '{8'hFF, 1'b0, 32'h0,         32'h0};

    wait_c(3);
    chk("rst_sync", {31'h0, sync_out}, 0);
    chk("rst_miso", {31'h0, miso}, 0);
    chk("rst_q", q, 0);
    rst_n = 1'b1;
    rel = cyc;

    wait_rise(r1);
    chk("first_sync", r1 - rel, 156);
    sync_width(w);
    chk("sync_w1", w, 8);
    host_op(8'h01, 0, 0, 32'h1, "cnt1");
    host_op(8'h02, 0, 0, 32'h2001, "gyx1");

    for (int i = 0; i < 13; i++)
      host_op(tab[i].a, tab[i].w, tab[i].dd,
              tab[i].e, $sformatf("tab%0d", i));

    wait_rise(r2);
    chk("period1", r2 - r1, 156);
    sync_width(w);
    chk("sync_w2", w, 8);
    host_op(8'h01, 0, 0, 32'h2, "cnt2");
    wait_rise(r3);
    chk("period2", r3 - r2, 156);
    sync_width(w);
    host_op(8'h01, 0, 0, 32'h3, "cnt3");
    host_op(8'h07, 0, 0, 32'h7003, "acz3");

    spi_frame(16'h7200, 16, 16'h0000, "spi_rd39");
    spi_frame(16'h0000, 16, 16'h404C, "spi_pid");
    spi_frame(16'h9034, 16, 16'hA5A5, "spi_wlo");
    spi_frame(16'h9112, 16, 16'h0000, "spi_whi");
    spi_frame(16'h1000, 16, 16'h0000, "spi_rd08");
    spi_frame(16'h0000, 16, 16'h1234, "spi_got");
    host_op(8'h08, 0, 0, 32'h1234, "host_w08");
    spi_frame(16'hF2AA, 16, 16'hA5A5, "spi_wpid");
    host_op(8'h39, 0, 0, 32'h404C, "pid_kept");

    spi_frame(16'h1000, 16, 16'h0000, "spi_rd08b");
    spi_frame(16'h9155, 9, 16'h1200, "spi_abort");
    host_op(8'h08, 0, 0, 32'h1234, "w08_kept");
    spi_frame(16'h0000, 16, 16'h1234, "spi_keep");

    tx = 16'h9155;
    cs = 1'b0;
    wait_c(8);
    for (int i = 0; i < 5; i++)
      spi_bit(tx[15-i], r);
    rst_n = 1'b0;
    wait_c(2);
    chk("mid_miso", {31'h0, miso}, 0);
    chk("mid_sync", {31'h0, sync_out}, 0);
    chk("mid_q", q, 0);
    rst_n = 1'b1;
    rel = cyc;
    host_op(8'h01, 0, 0, 32'h0, "cnt_rst");
    wait_rise(r1);
    chk("sync_rst", r1 - rel, 156);
    cs = 1'b1;
    wait_c(8);
    spi_frame(16'h0000, 16, 16'h0000, "spi_first");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
